// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin scheduler sharing one serial pattern matcher
// among four bit-serial requesters, with per-frame hit count report.
module seq_det_sched #(
  parameter int FRAME_LEN = 16,
  parameter int PLEN = 5,
  parameter logic [PLEN-1:0] PATTERN = 5'b00110,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [3:0]       req,
  input  logic [3:0]       bit_in,
  output logic [3:0]       gnt,
  output logic             match,
  output logic             done,
  output logic             abort,
  output logic [1:0]       done_ch,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  state_t           state, state_d;
  logic [1:0]       last, last_d;
  logic [PLEN-1:0]  hist, hist_d;
  logic [7:0]       bitcnt, bitcnt_d;
  logic [CNT_W-1:0] prev_cnt, prev_d;
  logic [CNT_W-1:0] cnt_d;
  logic [3:0]       gnt_d;
  logic             match_d, done_d, abort_d;
  logic [1:0]       done_ch_d;

  logic [1:0]       win, idx;
  logic             found;
  logic             b, hit;
  logic [PLEN:0]    ext;

  always_comb begin
    win   = last;
    found = 1'b0;
    idx   = last;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Window includes the bit being sampled now; valid once PLEN bits seen.
  assign b   = bit_in[last];
  assign ext = {hist, b};
  assign hit = (ext[PLEN-1:0] == PATTERN) &&
               ({1'b0, bitcnt} >= 9'(PLEN - 1));

  always_comb begin
    state_d   = state;
    last_d    = last;
    hist_d    = hist;
    bitcnt_d  = bitcnt;
    prev_d    = prev_cnt;
    cnt_d     = match_cnt;
    gnt_d     = gnt;
    match_d   = 1'b0;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    done_ch_d = done_ch;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_d  = RUN;
          last_d   = win;
          gnt_d    = 4'b0001 << win;
          hist_d   = '0;
          bitcnt_d = '0;
          prev_d   = match_cnt;
          cnt_d    = '0;
        end
      end
      RUN: begin
        if (!req[last]) begin
          state_d = IDLE;
          gnt_d   = '0;
          abort_d = 1'b1;
          cnt_d   = prev_cnt;
        end else begin
          hist_d   = ext[PLEN-1:0];
          bitcnt_d = bitcnt + 8'd1;
          if (hit) begin
            match_d = 1'b1;
            if (!(&match_cnt)) cnt_d = match_cnt + 1'b1;
          end
          if (bitcnt == 8'(FRAME_LEN - 1)) begin
            state_d   = REPORT;
            gnt_d     = '0;
            done_d    = 1'b1;
            done_ch_d = last;
          end
        end
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      last      <= 2'd3;
      hist      <= '0;
      bitcnt    <= '0;
      prev_cnt  <= '0;
      match_cnt <= '0;
      gnt       <= '0;
      match     <= 1'b0;
      done      <= 1'b0;
      abort     <= 1'b0;
      done_ch   <= '0;
    end else begin
      state     <= state_d;
      last      <= last_d;
      hist      <= hist_d;
      bitcnt    <= bitcnt_d;
      prev_cnt  <= prev_d;
      match_cnt <= cnt_d;
      gnt       <= gnt_d;
      match     <= match_d;
      done      <= done_d;
      abort     <= abort_d;
      done_ch   <= done_ch_d;
    end
  end

  assign busy = (state == RUN);

endmodule
